// File: rtl/sram_ctrl_pkg.sv
// Shared types and sizing helpers for the SRAM burst controller.
package sram_ctrl_pkg;

  // Transaction sequencer states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Number of SRAM beats needed to move one CPU word.
  function automatic int calc_beats(input int data_w, input int dq_w);
    return data_w / dq_w;
  endfunction

  // Counter width able to hold 0..n-1; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sram_beat_timer.sv
// Wait/beat counters that pace one burst of SRAM accesses.
module sram_beat_timer
  import sram_ctrl_pkg::*;
#(
  parameter int BEATS       = 2,
  parameter int WAIT_CYCLES = 4,
  localparam int BEAT_W     = cnt_w(BEATS),
  localparam int WAIT_W     = cnt_w(WAIT_CYCLES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              run,
  output logic [BEAT_W-1:0] beat,
  output logic              last_wait,
  output logic              last_beat
);

  logic [WAIT_W-1:0] wait_cnt;

  assign last_wait = (wait_cnt == WAIT_W'(WAIT_CYCLES - 1));
  assign last_beat = (beat == BEAT_W'(BEATS - 1));

  // Count wait cycles within a beat, then advance the beat index.
  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      wait_cnt <= '0;
      beat     <= '0;
    end else if (run) begin
      if (last_wait) begin
        wait_cnt <= '0;
        beat     <= last_beat ? '0 : beat + BEAT_W'(1);
      end else begin
        wait_cnt <= wait_cnt + WAIT_W'(1);
      end
    end
  end

endmodule

// File: rtl/sram_burst_controller.sv
// Bridges one CPU load/store onto a narrow asynchronous SRAM as a burst of
// fixed-length beats, stalling the pipeline through `ready` meanwhile.
module sram_burst_controller
  import sram_ctrl_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int SRAM_DQ_W   = 16,
  parameter int SRAM_ADDR_W = 18,
  parameter int WAIT_CYCLES = 4,
  parameter int ADDR_OFFSET = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic                   rd_en,
  input  logic [31:0]            address,
  input  logic [DATA_W-1:0]      write_data,
  output logic [DATA_W-1:0]      read_data,
  output logic                   ready,
  inout  wire  [SRAM_DQ_W-1:0]   sram_dq,
  output logic [SRAM_ADDR_W-1:0] sram_address,
  output logic                   SRAM_UB_N,
  output logic                   SRAM_LB_N,
  output logic                   SRAM_CE_N,
  output logic                   SRAM_WE_N,
  output logic                   SRAM_OE_N
);

  localparam int BEATS      = calc_beats(DATA_W, SRAM_DQ_W);
  localparam int BEAT_W     = cnt_w(BEATS);
  localparam int BYTE_SHIFT = $clog2(DATA_W / 8);

  state_t                 state, state_next;
  logic                   start;
  logic                   op_write;
  logic                   dq_drive;
  logic                   sample;
  logic                   last_wait;
  logic                   last_beat;
  logic [BEAT_W-1:0]      beat;
  logic [31:0]            word_idx;
  logic [SRAM_ADDR_W-1:0] base_q;
  logic [DATA_W-1:0]      wdata_q;
  logic [DATA_W-1:0]      asm_q;
  logic [DATA_W-1:0]      asm_next;
  logic [SRAM_DQ_W-1:0]   wr_slice;

  // CPU byte address -> CPU word index; the SRAM base is word*BEATS, wrapping silently.
  assign word_idx = (address - 32'(ADDR_OFFSET)) >> BYTE_SHIFT;

  sram_beat_timer #(
    .BEATS       (BEATS),
    .WAIT_CYCLES (WAIT_CYCLES)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .clear     (state != ACCESS),
    .run       (state == ACCESS),
    .beat      (beat),
    .last_wait (last_wait),
    .last_beat (last_beat)
  );

  // State register; a synchronous reset abandons any burst in flight.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Next-state decode: one burst per request, a single DONE cycle, no merging.
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    start      = 1'b0;
    case (state)
      IDLE: begin
        if (wr_en || rd_en) begin
          start      = 1'b1;
          state_next = ACCESS;
        end
      end
      ACCESS:  if (last_wait && last_beat) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Read assembly: drop the current SRAM word into its slice, LSB slice first.
  always_comb begin
    asm_next = asm_q;
    asm_next[int'(beat)*SRAM_DQ_W +: SRAM_DQ_W] = sram_dq;
  end

  assign sample = (state == ACCESS) && !op_write && last_wait;

  // Operand capture at request time and read-word assembly during the burst.
  // NOTE: the assembly and result registers are reset too, so read_data is a known 0 after reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      op_write  <= 1'b0;
      base_q    <= '0;
      wdata_q   <= '0;
      asm_q     <= '0;
      read_data <= '0;
    end else begin
      if (start) begin
        op_write <= wr_en;  // a simultaneous read request loses to the write
        base_q   <= SRAM_ADDR_W'(word_idx * 32'(BEATS));
        wdata_q  <= write_data;
      end
      if (sample) begin
        asm_q <= asm_next;
        if (last_beat) read_data <= asm_next;
      end
    end
  end

  // SRAM bus drivers: data is held for the whole write burst, WE rises in the
  // last wait cycle of each beat (or stays low throughout with single-cycle beats).
  assign dq_drive     = (state == ACCESS) && op_write;
  assign wr_slice     = wdata_q[int'(beat)*SRAM_DQ_W +: SRAM_DQ_W];
  assign sram_dq      = dq_drive ? wr_slice : {SRAM_DQ_W{1'bz}};
  assign sram_address = base_q + SRAM_ADDR_W'(beat);
  assign SRAM_WE_N    = ~(dq_drive && ((WAIT_CYCLES == 1) || !last_wait));
  assign SRAM_OE_N    = 1'b0;
  assign SRAM_UB_N    = 1'b0;
  assign SRAM_LB_N    = 1'b0;
  assign SRAM_CE_N    = 1'b0;

  // Stall the CPU while a request is pending and not yet finished.
  assign ready = ~(wr_en | rd_en) | (state == DONE);

endmodule
